// File: rtl/sw_order_capture.sv
// Switch input conditioner: synchronise, debounce and edge-detect each slide switch,
// then rank debounced rises in arrival order into an octal-packed vector.
module sw_order_capture #(
  parameter int unsigned N_SW     = 6,
  parameter int unsigned DEBOUNCE = 2800000,
  parameter int unsigned RANK_W   = 3
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [N_SW-1:0]          sw_raw,
  input  logic                     restart,
  output logic [N_SW-1:0]          sw_stable,
  output logic [N_SW-1:0]          rise_p,
  output logic [N_SW*RANK_W-1:0]   order,
  output logic                     all_off,
  output logic                     rank_full
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned ORD_W = N_SW * RANK_W;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [RANK_W-1:0] RANK_MAX = RANK_W'((1 << RANK_W) - 1);
  localparam logic [RANK_W-1:0] RANK_ONE = RANK_W'(1);

  logic [N_SW-1:0]   sync1_q, sync2_q;
  logic [N_SW-1:0]   stable_q, stable_d;
  logic [N_SW-1:0]   rise_q, rise_d;
  logic [CNT_W-1:0]  cnt_q [N_SW];
  logic [CNT_W-1:0]  cnt_d [N_SW];
  logic [ORD_W-1:0]  order_q, order_d;
  logic [RANK_W-1:0] next_rank_q, next_rank_d;
  logic [RANK_W-1:0] rank_ptr;
  logic              all_off_q, all_off_d;
  logic              rank_full_q, rank_full_d;

  // Per-channel debounce: accept a new level after DEBOUNCE consecutive differing cycles
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_SW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  // Rank rises lowest index first; pointer saturates at the top rank value
  always_comb begin
    order_d  = order_q;
    rank_ptr = next_rank_q;
    for (int i = 0; i < N_SW; i++) begin
      if (rise_d[i]) begin
        order_d[i*RANK_W +: RANK_W] = rank_ptr;
        if (rank_ptr != RANK_MAX) begin
          rank_ptr = rank_ptr + RANK_W'(1);
        end
      end
    end
    next_rank_d = rank_ptr;
    if (restart) begin
      order_d     = '0;
      next_rank_d = RANK_ONE;
    end
    rank_full_d = (next_rank_d == RANK_MAX);
    all_off_d   = ~|stable_q;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      rise_q      <= '0;
      order_q     <= '0;
      next_rank_q <= RANK_ONE;
      all_off_q   <= 1'b1;
      rank_full_q <= 1'b0;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sw_raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      rise_q      <= rise_d;
      order_q     <= order_d;
      next_rank_q <= next_rank_d;
      all_off_q   <= all_off_d;
      rank_full_q <= rank_full_d;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_stable = stable_q;
  assign rise_p    = rise_q;
  assign order     = order_q;
  assign all_off   = all_off_q;
  assign rank_full = rank_full_q;

endmodule

// File: tb/tb_sw_order_capture.sv
// Bench for sw_order_capture: directed scenarios plus random switch activity
// compared against a cycle-level reference model of the ranking rules.
module tb_sw_order_capture;

  localparam int DEB = 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic        restart;
  logic [5:0]  sw_raw;
  logic [5:0]  sw_stable;
  logic [5:0]  rise_p;
  logic [17:0] order;
  logic        all_off;
  logic        rank_full;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit [5:0] m_h1, m_h2, m_st, m_rp;
  int       m_run  [6];
  int       m_rank [6];
  int       m_nxt;
  bit       m_alloff, m_full;

  always #5 CLK = ~CLK;

  sw_order_capture #(.N_SW(6), .DEBOUNCE(DEB), .RANK_W(3)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .restart   (restart),
    .sw_stable (sw_stable),
    .rise_p    (rise_p),
    .order     (order),
    .all_off   (all_off),
    .rank_full (rank_full)
  );

  task automatic m_clear();
    m_h1 = '0; m_h2 = '0; m_st = '0; m_rp = '0;
    for (int i = 0; i < 6; i++) begin
      m_run[i]  = 0;
      m_rank[i] = 0;
    end
    m_nxt = 1; m_alloff = 1'b1; m_full = 1'b0;
  endtask

  // one clock edge of the reference model, using the pre-edge inputs
  task automatic m_step();
    bit [5:0] ns;
    ns = m_st;
    for (int i = 0; i < 6; i++) begin
      if (m_h2[i] != m_st[i]) begin
        m_run[i]++;
        if (m_run[i] >= DEB) begin
          ns[i]    = m_h2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_rp     = ns & ~m_st;
    m_alloff = (m_st == 6'd0);
    if (restart) begin
      for (int i = 0; i < 6; i++) m_rank[i] = 0;
      m_nxt = 1;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (m_rp[i]) begin
          m_rank[i] = m_nxt;
          m_nxt     = (m_nxt < 7) ? m_nxt + 1 : 7;
        end
      end
    end
    m_full = (m_nxt == 7);
    m_st   = ns;
    m_h2   = m_h1;
    m_h1   = sw_raw;
  endtask

  function automatic logic [17:0] m_order();
    logic [17:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[i*3 +: 3] = 3'(m_rank[i]);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      if (!reset) m_step();
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; restart = 1'b0; sw_raw = '0;
    m_clear();
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    tick(1);
    n_checks += 5;
    if (sw_stable !== 6'd0) begin n_fail++; $display("FAIL rst_stable got %b want 0", sw_stable); end
    if (rise_p !== 6'd0) begin n_fail++; $display("FAIL rst_rise got %b want 0", rise_p); end
    if (order !== 18'd0) begin n_fail++; $display("FAIL rst_order got %o want 0", order); end
    if (all_off !== 1'b1) begin n_fail++; $display("FAIL rst_all_off got %b want 1", all_off); end
    if (rank_full !== 1'b0) begin n_fail++; $display("FAIL rst_rank_full got %b want 0", rank_full); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    sw_raw = 6'b000001;
    tick(5);
    n_checks++;
    if (sw_stable !== 6'd0) begin n_fail++; $display("FAIL single_early got %b want 0", sw_stable); end
    tick(1);
    n_checks += 4;
    if (sw_stable !== 6'b000001) begin n_fail++; $display("FAIL single_stable got %b want 000001", sw_stable); end
    if (rise_p !== 6'b000001) begin n_fail++; $display("FAIL single_rise got %b want 000001", rise_p); end
    if (order !== 18'o000001) begin n_fail++; $display("FAIL single_order got %o want 000001", order); end
    if (all_off !== 1'b1) begin n_fail++; $display("FAIL single_all_off_lag got %b want 1", all_off); end
    tick(1);
    n_checks += 3;
    if (rise_p !== 6'd0) begin n_fail++; $display("FAIL single_rise_len got %b want 0", rise_p); end
    if (all_off !== 1'b0) begin n_fail++; $display("FAIL single_all_off got %b want 0", all_off); end
    if (order !== 18'o000001) begin n_fail++; $display("FAIL single_order_hold got %o want 000001", order); end
  endtask

  task automatic test_bounce();
    bit seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      sw_raw[0] = seq[k];
      tick(1);
      n_checks++;
      if (rise_p[0] !== 1'b0) begin n_fail++; $display("FAIL bounce_quiet k=%0d got %b want 0", k, rise_p[0]); end
    end
    sw_raw[0] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick(1);
      n_checks++;
      if (rise_p[0] !== (c == 6)) begin
        n_fail++; $display("FAIL bounce_rise c=%0d got %b want %b", c, rise_p[0], (c == 6));
      end
    end
    n_checks++;
    if (order !== 18'o000001) begin n_fail++; $display("FAIL bounce_order got %o want 000001", order); end
  endtask

  task automatic test_staggered();
    do_reset();
    sw_raw[2] = 1'b1; tick(20);
    sw_raw[0] = 1'b1; tick(20);
    sw_raw[5] = 1'b1; tick(20);
    n_checks += 2;
    if (order !== 18'o300102) begin n_fail++; $display("FAIL stagger_order got %o want 300102", order); end
    if (rank_full !== 1'b0) begin n_fail++; $display("FAIL stagger_full got %b want 0", rank_full); end
    sw_raw[1] = 1'b1; tick(20);
    n_checks++;
    if (order !== 18'o300142) begin n_fail++; $display("FAIL stagger_next got %o want 300142", order); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    sw_raw = 6'b001010;
    tick(6);
    n_checks += 2;
    if (rise_p !== 6'b001010) begin n_fail++; $display("FAIL simul_rise got %b want 001010", rise_p); end
    if (order !== 18'o002010) begin n_fail++; $display("FAIL simul_order got %o want 002010", order); end
  endtask

  task automatic test_saturate();
    do_reset();
    sw_raw = 6'h3f;
    tick(8);
    n_checks += 2;
    if (order !== 18'o654321) begin n_fail++; $display("FAIL sat_all got %o want 654321", order); end
    if (rank_full !== 1'b1) begin n_fail++; $display("FAIL sat_full got %b want 1", rank_full); end
    for (int r = 0; r < 2; r++) begin
      sw_raw[0] = 1'b0; tick(10);
      n_checks++;
      if (order !== ((r == 0) ? 18'o654321 : 18'o654327)) begin
        n_fail++; $display("FAIL sat_fall r=%0d got %o", r, order);
      end
      sw_raw[0] = 1'b1; tick(10);
      n_checks += 2;
      if (order !== 18'o654327) begin n_fail++; $display("FAIL sat_rerise r=%0d got %o want 654327", r, order); end
      if (rank_full !== 1'b1) begin n_fail++; $display("FAIL sat_full_hold r=%0d got %b want 1", r, rank_full); end
    end
  endtask

  task automatic test_restart();
    do_reset();
    sw_raw = 6'b000001; tick(10);
    sw_raw[4] = 1'b1; tick(5);
    restart = 1'b1; tick(1);
    restart = 1'b0;
    n_checks += 3;
    if (rise_p !== 6'b010000) begin n_fail++; $display("FAIL restart_rise got %b want 010000", rise_p); end
    if (order !== 18'd0) begin n_fail++; $display("FAIL restart_order got %o want 0", order); end
    if (rank_full !== 1'b0) begin n_fail++; $display("FAIL restart_full got %b want 0", rank_full); end
    sw_raw[1] = 1'b1; tick(8);
    n_checks++;
    if (order !== 18'o000010) begin n_fail++; $display("FAIL restart_next got %o want 000010", order); end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    sw_raw[2] = 1'b1;
    tick(4);
    reset = 1'b1;
    m_clear();
    tick(1);
    reset = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick(1);
      n_checks++;
      if (rise_p[2] !== (c == 6)) begin
        n_fail++; $display("FAIL midrst_rise c=%0d got %b want %b", c, rise_p[2], (c == 6));
      end
    end
    n_checks++;
    if (order !== 18'o000100) begin n_fail++; $display("FAIL midrst_order got %o want 000100", order); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 9) == 0) sw_raw[i] = ~sw_raw[i];
      end
      restart = ($urandom_range(0, 49) == 0);
      tick(1);
      n_checks += 5;
      if (sw_stable !== m_st) begin n_fail++; $display("FAIL rand_stable c=%0d got %b want %b", c, sw_stable, m_st); end
      if (rise_p !== m_rp) begin n_fail++; $display("FAIL rand_rise c=%0d got %b want %b", c, rise_p, m_rp); end
      if (order !== m_order()) begin n_fail++; $display("FAIL rand_order c=%0d got %o want %o", c, order, m_order()); end
      if (all_off !== m_alloff) begin n_fail++; $display("FAIL rand_all_off c=%0d got %b want %b", c, all_off, m_alloff); end
      if (rank_full !== m_full) begin n_fail++; $display("FAIL rand_full c=%0d got %b want %b", c, rank_full, m_full); end
    end
    restart = 1'b0;
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; sw_raw = '0;
    m_clear();
    test_reset();
    test_single();
    test_bounce();
    test_staggered();
    test_simultaneous();
    test_saturate();
    test_restart();
    test_reset_mid_debounce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
